// File: rtl/wave_seq_ctrl.sv
// Sequencer for the waveform generator's 8:1 bit-select mux: steps sel through a pattern in up/down/ping-pong order.
// Optional one-shot mode (stop after one pattern period) is enabled by defining WAVE_SEQ_ONE_SHOT_EN.
module wave_seq_ctrl #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [7:0]       pattern_in,
    input  logic [DIV_W-1:0] div,
    input  logic [1:0]       mode,
    input  logic             start,
    input  logic             stop,
    output logic [2:0]       sel,
    output logic             wave,
    output logic             busy,
    output logic             wrap,
    output logic             done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [7:0]       pattern_reg;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_q;
    logic [1:0]       mode_q;
    logic             dir_up;

    logic [2:0]       step_sel;
    logic             step_dir_up;
    logic             period_end;
    logic             tick;

`ifdef WAVE_SEQ_ONE_SHOT_EN
    logic             done_r;
    assign done = done_r;
`else
    assign done = 1'b0;
`endif

    assign tick = (cnt == div_q);
    assign wave = busy & pattern_reg[sel];

    // Next select value for the latched mode; period_end marks the step that closes a period.
    always_comb begin
        step_sel    = sel;
        step_dir_up = dir_up;
        period_end  = 1'b0;
        case (mode_q)
            2'b00: begin
                step_sel   = sel + 3'd1;
                period_end = (sel == 3'd7);
            end
            2'b01: begin
                step_sel   = sel - 3'd1;
                period_end = (sel == 3'd0);
            end
            2'b10: begin
                if (dir_up) begin
                    if (sel == 3'd7) begin
                        step_sel    = 3'd6;
                        step_dir_up = 1'b0;
                    end else begin
                        step_sel = sel + 3'd1;
                    end
                end else begin
                    if (sel == 3'd0) begin
                        step_sel    = 3'd1;
                        step_dir_up = 1'b1;
                    end else begin
                        step_sel = sel - 3'd1;
                    end
                    period_end = (sel == 3'd1);
                end
            end
            default: begin
                step_sel   = sel;
                period_end = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pattern_reg <= 8'd0;
            sel         <= 3'd0;
            dir_up      <= 1'b1;
            cnt         <= '0;
            div_q       <= '0;
            mode_q      <= 2'b00;
            busy        <= 1'b0;
            wrap        <= 1'b0;
`ifdef WAVE_SEQ_ONE_SHOT_EN
            done_r      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    wrap <= 1'b0;
`ifdef WAVE_SEQ_ONE_SHOT_EN
                    done_r <= 1'b0;
`endif
                    if (load) begin
                        pattern_reg <= pattern_in;
                    end
                    if (start && !stop) begin
                        state  <= RUN;
                        busy   <= 1'b1;
                        div_q  <= div;
                        mode_q <= mode;
                        cnt    <= '0;
                        sel    <= (mode == 2'b01) ? 3'd7 : 3'd0;
                        dir_up <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        // Abort wins over any step landing on the same edge, so no wrap pulse.
                        state <= IDLE;
                        busy  <= 1'b0;
                        sel   <= 3'd0;
                        cnt   <= '0;
                        wrap  <= 1'b0;
`ifdef WAVE_SEQ_ONE_SHOT_EN
                        done_r <= 1'b0;
`endif
                    end else if (tick) begin
                        cnt  <= '0;
                        wrap <= period_end;
`ifdef WAVE_SEQ_ONE_SHOT_EN
                        if (period_end) begin
                            state  <= IDLE;
                            busy   <= 1'b0;
                            sel    <= 3'd0;
                            dir_up <= 1'b1;
                            done_r <= 1'b1;
                        end else begin
                            sel    <= step_sel;
                            dir_up <= step_dir_up;
                            done_r <= 1'b0;
                        end
`else
                        sel    <= step_sel;
                        dir_up <= step_dir_up;
`endif
                    end else begin
                        cnt  <= cnt + DIV_W'(1);
                        wrap <= 1'b0;
`ifdef WAVE_SEQ_ONE_SHOT_EN
                        done_r <= 1'b0;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wave_seq_ctrl.sv
// Directed self-checking bench for wave_seq_ctrl; adapts its expectations when WAVE_SEQ_ONE_SHOT_EN is defined.
module tb_wave_seq_ctrl;

    localparam int DIV_W = 8;
`ifdef WAVE_SEQ_ONE_SHOT_EN
    localparam logic OS = 1'b1;
`else
    localparam logic OS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             load;
    logic [7:0]       pattern_in;
    logic [DIV_W-1:0] div;
    logic [1:0]       mode;
    logic             start;
    logic             stop;
    logic [2:0]       sel;
    logic             wave;
    logic             busy;
    logic             wrap;
    logic             done;

    int n_checks = 0;
    int n_fail   = 0;

    wave_seq_ctrl #(.DIV_W(DIV_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .pattern_in (pattern_in),
        .div        (div),
        .mode       (mode),
        .start      (start),
        .stop       (stop),
        .sel        (sel),
        .wave       (wave),
        .busy       (busy),
        .wrap       (wrap),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b0; pattern_in = 8'd0; div = '0; mode = 2'b00; start = 1'b0; stop = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if (sel !== 3'd0 || busy !== 1'b0 || wrap !== 1'b0 || done !== 1'b0 || wave !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: sel=%0d busy=%b wrap=%b done=%b wave=%b, required all 0", sel, busy, wrap, done, wave);
        end
    endtask

    task automatic test_up();
        int exp_w[8];
        exp_w = '{0, 0, 0, 1, 1, 1, 0, 1};
        load = 1'b1; pattern_in = 8'b1011_1000;
        tick();
        load = 1'b0; mode = 2'b00; div = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (sel !== 3'(i) || wave !== exp_w[i][0] || wrap !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL up_step%0d: sel=%0d wave=%b wrap=%b busy=%b done=%b, required sel=%0d wave=%0d wrap=0 busy=1 done=0",
                         i, sel, wave, wrap, busy, done, i, exp_w[i]);
            end
            tick();
        end
        n_checks++;
        if (sel !== 3'd0 || wrap !== 1'b1 || busy !== !OS || done !== OS) begin
            n_fail++;
            $display("FAIL up_wrap: sel=%0d wrap=%b busy=%b done=%b, required sel=0 wrap=1 busy=%b done=%b",
                     sel, wrap, busy, done, !OS, OS);
        end
        tick();
        n_checks++;
        if (wrap !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL up_wrap_len: wrap=%b done=%b, required 0 0", wrap, done);
        end
`ifndef WAVE_SEQ_ONE_SHOT_EN
        n_checks++;
        if (sel !== 3'd1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL up_freerun: sel=%0d busy=%b, required sel=1 busy=1", sel, busy);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
`endif
        n_checks++;
        if (busy !== 1'b0 || sel !== 3'd0 || wave !== 1'b0) begin
            n_fail++;
            $display("FAIL up_idle: busy=%b sel=%0d wave=%b, required 0 0 0", busy, sel, wave);
        end
    endtask

    task automatic test_down();
        int exp_w[8];
        exp_w = '{1, 0, 1, 1, 1, 0, 0, 0};
        mode = 2'b01; div = 8'd2; start = 1'b1;
        tick();
        start = 1'b0; mode = 2'b00; div = 8'd0;
        for (int j = 0; j < 8; j++) begin
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (sel !== 3'(7 - j) || wave !== exp_w[j][0] || wrap !== 1'b0 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL down_step%0d_%0d: sel=%0d wave=%b wrap=%b busy=%b, required sel=%0d wave=%0d wrap=0 busy=1",
                             j, k, sel, wave, wrap, busy, 7 - j, exp_w[j]);
                end
                tick();
            end
        end
        n_checks++;
        if (sel !== (OS ? 3'd0 : 3'd7) || wrap !== 1'b1 || done !== OS) begin
            n_fail++;
            $display("FAIL down_wrap: sel=%0d wrap=%b done=%b, required sel=%0d wrap=1 done=%b",
                     sel, wrap, done, OS ? 0 : 7, OS);
        end
        tick();
        n_checks++;
        if (wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL down_wrap_len: wrap=%b, required 0", wrap);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_pingpong();
        int seq[14];
        seq = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1};
        mode = 2'b10; div = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            n_checks++;
            if (sel !== 3'(seq[i]) || wrap !== 1'b0) begin
                n_fail++;
                $display("FAIL pp_step%0d: sel=%0d wrap=%b, required sel=%0d wrap=0", i, sel, wrap, seq[i]);
            end
            tick();
        end
        n_checks++;
        if (sel !== 3'd0 || wrap !== 1'b1) begin
            n_fail++;
            $display("FAIL pp_wrap: sel=%0d wrap=%b, required sel=0 wrap=1", sel, wrap);
        end
`ifndef WAVE_SEQ_ONE_SHOT_EN
        tick();
        n_checks++;
        if (sel !== 3'd1 || wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL pp_no_repeat0: sel=%0d wrap=%b, required sel=1 wrap=0", sel, wrap);
        end
        for (int i = 0; i < 7; i++) tick();
        n_checks++;
        if (sel !== 3'd6) begin
            n_fail++;
            $display("FAIL pp_no_repeat7: sel=%0d, required 6", sel);
        end
`endif
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_ignore_and_stop();
        int exp_w[8];
        exp_w = '{0, 0, 0, 1, 1, 1, 0, 1};
        mode = 2'b00; div = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        load = 1'b1; pattern_in = 8'hFF; div = 8'd5; mode = 2'b01; start = 1'b1;
        for (int i = 1; i < 8; i++) begin
            n_checks++;
            if (sel !== 3'(i) || wave !== exp_w[i][0] || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL ignore_step%0d: sel=%0d wave=%b busy=%b, required sel=%0d wave=%0d busy=1",
                         i, sel, wave, busy, i, exp_w[i]);
            end
            if (i < 7) tick();
        end
        stop = 1'b1;
        tick();
        load = 1'b0; start = 1'b0; stop = 1'b0; div = 8'd0; mode = 2'b00;
        n_checks++;
        if (busy !== 1'b0 || sel !== 3'd0 || wrap !== 1'b0 || wave !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_vs_step: busy=%b sel=%0d wrap=%b wave=%b done=%b, required all 0", busy, sel, wrap, wave, done);
        end
        stop = 1'b1; start = 1'b1;
        tick(); tick();
        stop = 1'b0; start = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_with_stop: busy=%b, required 0", busy);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        n_checks++;
        if (sel !== 3'd1 || wave !== 1'b0) begin
            n_fail++;
            $display("FAIL pattern_kept: sel=%0d wave=%b, required sel=1 wave=0", sel, wave);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        mode = 2'b11; div = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (sel !== 3'd0 || wrap !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL freeze%0d: sel=%0d wrap=%b busy=%b done=%b, required sel=0 wrap=0 busy=1 done=0",
                         i, sel, wrap, busy, done);
            end
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0; mode = 2'b00;
    endtask

    task automatic test_reset_midrun();
        mode = 2'b00; div = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        n_checks++;
        if (sel !== 3'd5 || wave !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: sel=%0d wave=%b, required sel=5 wave=1", sel, wave);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (sel !== 3'd0 || busy !== 1'b0 || wrap !== 1'b0 || wave !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_reset: sel=%0d busy=%b wrap=%b wave=%b, required all 0", sel, busy, wrap, wave);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (sel !== 3'(i) || busy !== 1'b1 || wave !== 1'b0) begin
                n_fail++;
                $display("FAIL cleared_pattern%0d: sel=%0d busy=%b wave=%b, required sel=%0d busy=1 wave=0",
                         i, sel, busy, wave, i);
            end
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

`ifdef WAVE_SEQ_ONE_SHOT_EN
    task automatic test_one_shot();
        load = 1'b1; pattern_in = 8'b1011_1000;
        tick();
        load = 1'b0; mode = 2'b00; div = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (busy !== 1'b1 || sel !== 3'(i / 2) || done !== 1'b0) begin
                n_fail++;
                $display("FAIL oneshot_busy%0d: busy=%b sel=%0d done=%b, required busy=1 sel=%0d done=0",
                         i, busy, sel, done, i / 2);
            end
            tick();
        end
        n_checks++;
        if (busy !== 1'b0 || wrap !== 1'b1 || done !== 1'b1 || sel !== 3'd0 || wave !== 1'b0) begin
            n_fail++;
            $display("FAIL oneshot_end: busy=%b wrap=%b done=%b sel=%0d wave=%b, required 0 1 1 0 0",
                     busy, wrap, done, sel, wave);
        end
        tick();
        n_checks++;
        if (wrap !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL oneshot_pulse: wrap=%b done=%b busy=%b, required 0 0 0", wrap, done, busy);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        n_checks++;
        if (busy !== 1'b1 || sel !== 3'd1) begin
            n_fail++;
            $display("FAIL oneshot_restart: busy=%b sel=%0d, required busy=1 sel=1", busy, sel);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_up();
        test_down();
        test_pingpong();
        test_ignore_and_stop();
        test_reset_midrun();
`ifdef WAVE_SEQ_ONE_SHOT_EN
        test_one_shot();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
